mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory-stage controller: the consumer/reader side of the Execution-Memory pipeline register.
- Takes the EX/MEM outputs (control flags, register index, ALU result, address) and performs the data-memory load or store through a req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Registers the result into the Memory-Writeback stage outputs.

Parameters:
N  32  data/address width
M  4  register-index width
TIMEOUT  15  max WAIT cycles before abort (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset
pcload_M  in  1  branch/PC-load flag from EX/MEM
regw_M  in  1  register write enable from EX/MEM
memw_M  in  1  store flag from EX/MEM
regmem_M  in  1  load flag (result comes from memory) from EX/MEM
regScr_M  in  M  destination register index
ALUrslt_M  in  N  ALU result; store data when memw_M=1
address_M  in  N  memory address / PC target
mem_req  out  1  memory request
mem_we  out  1  1=write, 0=read
mem_addr  out  N  memory address
mem_wdata  out  N  store data
mem_ack  in  1  memory completion; mem_rdata valid in the same cycle
mem_rdata  in  N  load data
stall_M  out  1  hold upstream pipeline (EX/MEM and earlier)
pcload_W  out  1  registered PC-load flag
regw_W  out  1  registered register-write enable
regScr_W  out  M  registered destination index
result_W  out  N  registered writeback data
address_W  out  N  registered address / PC target
err_W  out  1  registered access-timeout flag

Behaviour:
- memop = memw_M | regmem_M. If memw_M and regmem_M are both 1, treat the access as a store (mem_we=1) and select writeback data from memory.
- Combinational outputs:
  - mem_req = memop & ~abort
  - mem_we = memw_M
  - mem_addr = address_M
  - mem_wdata = ALUrslt_M
- stall_M = memop & ~mem_ack & ~abort, where abort = (state==WAIT & wait_cnt==TIMEOUT & ~mem_ack); abort exists only with MEM_TIMEOUT_EN, otherwise abort=0.
- FSM states: IDLE, WAIT. wait_cnt is $clog2(TIMEOUT+1) bits and saturates.
- IDLE transitions:
  - memop & mem_ack: zero-wait access, stay in IDLE.
  - memop & ~mem_ack: go to WAIT, wait_cnt<=1.
  - ~memop: stay in IDLE; mem_ack is ignored.
- WAIT transitions:
  - mem_ack: go to IDLE, wait_cnt<=0.
  - abort: go to IDLE, wait_cnt<=0.
  - otherwise: wait_cnt++.
- Protocol: memory holds no state across mem_req deassertion and never acks while mem_req=0. The upstream must keep the *_M inputs stable while stall_M=1.
- W register update, every clock edge, 1-cycle latency:
  - stall_M=1: bubble. pcload_W=0, regw_W=0, err_W=0; regScr_W, result_W, address_W hold.
  - abort: bubble with err_W=1 for exactly one cycle.
  - otherwise capture the *_M inputs; result_W = regmem_M ? mem_rdata : ALUrslt_M.
- Reset (rst=0 at an edge): state=IDLE, wait_cnt=0, all *_W outputs=0. Reset mid-WAIT drops the access silently; no ack is expected afterwards.
- No memop (bubble or ALU-only): pass-through with 1-cycle latency and stall_M=0.
- Back-to-back memops: each completes independently; the next request may assert in the cycle after an ack.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined: the WAIT watchdog is active. After TIMEOUT WAIT cycles without mem_ack, the block aborts: mem_req drops, stall releases, and err_W pulses on the bubble.
- Undefined: WAIT lasts indefinitely, abort=0, and err_W is tied to 0. The port list is identical either way.

Decomposition:
- Package mem_stage_pkg holds:
  - state enum typedef (IDLE, WAIT)
  - default widths N_DEF=32, M_DEF=4
  - TIMEOUT_DEF=15
- One natural sub-module: the existing parameterised register is reused for each W field, with wen=1. The FSM and wait counter stay inline.

Test Plan:
- ALU op: regw_M=1, regScr_M=3, ALUrslt_M=0x0000_00AA, memop=0 -> next cycle regw_W=1, regScr_W=3, result_W=0xAA; stall_M=0 and mem_req=0 throughout.
- Zero-wait load: regmem_M=1, address_M=0x40, mem_ack=1 same cycle with mem_rdata=0x1234 -> mem_req=1, mem_we=0, stall_M=0; next cycle result_W=0x1234.
- 3-wait store: memw_M=1, address_M=0x80, ALUrslt_M=0xDEAD, ack on the 4th cycle -> mem_req=1, mem_we=1, mem_wdata=0xDEAD for 4 cycles; stall_M=1 for the first 3 cycles; W bubbles (regw_W=0) for 3 cycles, then capture.
- Reset asserted during WAIT (cycle 2 of a load) -> next edge: all *_W=0, state IDLE, stall_M=0 once the inputs are 0.
- MEM_TIMEOUT_EN, TIMEOUT=15, load never acked -> stall_M=1 for 15 cycles; abort on the 16th cycle with mem_req=0; err_W=1 for one cycle with regw_W=0.
- Back-to-back: load (ack after 1 wait) then ALU op -> exactly one stall cycle; W sequence is bubble, load result, ALU result.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and default sizes for the memory-stage controller.
// The optional access watchdog is enabled by defining MEM_TIMEOUT_EN.
package mem_stage_pkg;

  // Access FSM: IDLE accepts a new memop, WAIT holds it until ack (or abort).
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int N_DEF       = 32;  // data/address width
  localparam int M_DEF       = 4;   // register-index width
  localparam int TIMEOUT_DEF = 15;  // WAIT cycles before abort (watchdog builds only)

endpackage : mem_stage_pkg

// File: rtl/mem_stage_reg.sv
// Parameterised pipeline register with a synchronous active-low clear and a
// write enable. One instance is used for each Memory-Writeback field.
module mem_stage_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wen_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  // Clear on reset, otherwise load when enabled.
  // NOTE: reset is sampled inside the clocked block, so it only takes effect
  // on a rising edge; it is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_o <= '0;
    end else if (wen_i) begin
      q_o <= d_i;
    end
  end

endmodule : mem_stage_reg

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: reads the EX/MEM register, runs the data-memory
// load/store through a req/ack handshake, stalls upstream while an access is
// outstanding, and registers the result into the MEM/WB outputs.
// Optional feature: define MEM_TIMEOUT_EN to enable the WAIT watchdog, which
// aborts an access after TIMEOUT unacknowledged WAIT cycles and pulses err_W.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int M       = M_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  // EX/MEM stage inputs
  input  logic         pcload_M,
  input  logic         regw_M,
  input  logic         memw_M,
  input  logic         regmem_M,
  input  logic [M-1:0] regScr_M,
  input  logic [N-1:0] ALUrslt_M,
  input  logic [N-1:0] address_M,
  // data-memory handshake
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata,
  // pipeline control
  output logic         stall_M,
  // MEM/WB stage outputs
  output logic         pcload_W,
  output logic         regw_W,
  output logic [M-1:0] regScr_W,
  output logic [N-1:0] result_W,
  output logic [N-1:0] address_W,
  output logic         err_W
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_e          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            memop;
  logic            abort;

  // Next-state values for the MEM/WB fields.
  logic            pcload_d;
  logic            regw_d;
  logic [M-1:0]    regscr_d;
  logic [N-1:0]    result_d;
  logic [N-1:0]    address_d;

  // A store and a load flagged together is issued as a store; the writeback
  // mux below still picks memory data because regmem_M is set.
  assign memop = memw_M | regmem_M;

`ifdef MEM_TIMEOUT_EN
  // Watchdog fires in the cycle where the count has reached TIMEOUT and the
  // memory still has not answered.
  assign abort = (state_q == WAIT) && (wait_cnt_q == CW'(TIMEOUT)) && !mem_ack;
`else
  assign abort = 1'b0;
`endif

  // The request and the stall are purely combinational so a zero-wait access
  // completes in the same cycle it is presented.
  assign mem_req   = memop & ~abort;
  assign mem_we    = memw_M;
  assign mem_addr  = address_M;
  assign mem_wdata = ALUrslt_M;
  assign stall_M   = memop & ~mem_ack & ~abort;

  // State register for the access FSM and its WAIT-cycle counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic: enter WAIT on an unacknowledged memop, leave on ack or
  // abort. The counter saturates so it can never wrap back to a small value.
  // NOTE: every output of this block gets a default first, otherwise paths
  // that do not assign it would infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      IDLE: begin
        // Without a memop the ack line is ignored entirely.
        if (memop && !mem_ack) begin
          state_d    = WAIT;
          wait_cnt_d = CNT_ONE;
        end
      end
      WAIT: begin
        if (mem_ack || abort) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // MEM/WB capture: a stall or an abort inserts a bubble (control flags
  // cleared, data fields held); otherwise the EX/MEM fields pass through.
  always_comb begin
    pcload_d  = 1'b0;
    regw_d    = 1'b0;
    regscr_d  = regScr_W;
    result_d  = result_W;
    address_d = address_W;
    if (!stall_M && !abort) begin
      pcload_d  = pcload_M;
      regw_d    = regw_M;
      regscr_d  = regScr_M;
      result_d  = regmem_M ? mem_rdata : ALUrslt_M;
      address_d = address_M;
    end
  end

  mem_stage_reg #(.W(1)) u_pcload_w (
    .clk  (clk),
    .rst  (rst),
    .wen_i(1'b1),
    .d_i  (pcload_d),
    .q_o  (pcload_W)
  );

  mem_stage_reg #(.W(1)) u_regw_w (
    .clk  (clk),
    .rst  (rst),
    .wen_i(1'b1),
    .d_i  (regw_d),
    .q_o  (regw_W)
  );

  mem_stage_reg #(.W(M)) u_regscr_w (
    .clk  (clk),
    .rst  (rst),
    .wen_i(1'b1),
    .d_i  (regscr_d),
    .q_o  (regScr_W)
  );

  mem_stage_reg #(.W(N)) u_result_w (
    .clk  (clk),
    .rst  (rst),
    .wen_i(1'b1),
    .d_i  (result_d),
    .q_o  (result_W)
  );

  mem_stage_reg #(.W(N)) u_address_w (
    .clk  (clk),
    .rst  (rst),
    .wen_i(1'b1),
    .d_i  (address_d),
    .q_o  (address_W)
  );

`ifdef MEM_TIMEOUT_EN
  // The error flag is high only on the bubble that follows an abort.
  mem_stage_reg #(.W(1)) u_err_w (
    .clk  (clk),
    .rst  (rst),
    .wen_i(1'b1),
    .d_i  (abort),
    .q_o  (err_W)
  );
`else
  assign err_W = 1'b0;
`endif

endmodule : mem_stage_ctrl

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: a cycle-level model of the stage
// checks every output on every falling edge, and the directed sequence below
// adds hand-computed literal expectations.
module tb_mem_stage_ctrl;

  localparam int N  = 32;
  localparam int M  = 4;
  localparam int TO = 15;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         pcload_M, regw_M, memw_M, regmem_M;
  logic [M-1:0] regScr_M;
  logic [N-1:0] ALUrslt_M, address_M;
  logic         mem_req, mem_we;
  logic [N-1:0] mem_addr, mem_wdata;
  logic         mem_ack;
  logic [N-1:0] mem_rdata;
  logic         stall_M;
  logic         pcload_W, regw_W;
  logic [M-1:0] regScr_W;
  logic [N-1:0] result_W, address_W;
  logic         err_W;

  int n_checks = 0;
  int n_err    = 0;

  mem_stage_ctrl #(.N(N), .M(M), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .pcload_M (pcload_M),
    .regw_M   (regw_M),
    .memw_M   (memw_M),
    .regmem_M (regmem_M),
    .regScr_M (regScr_M),
    .ALUrslt_M(ALUrslt_M),
    .address_M(address_M),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .stall_M  (stall_M),
    .pcload_W (pcload_W),
    .regw_W   (regw_W),
    .regScr_W (regScr_W),
    .result_W (result_W),
    .address_W(address_W),
    .err_W    (err_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: tracks how many cycles the current access has been
  // outstanding and what the MEM/WB registers must hold after the next edge.
  // ---------------------------------------------------------------------
  bit           started;
  int           waited;
  logic         e_pc, e_rw, e_err;
  logic [M-1:0] e_scr;
  logic [N-1:0] e_res, e_addr;
  bit           m_memop, m_abort, m_req, m_stall;

  initial begin
    started = 1'b0;
    waited  = 0;
    forever begin
      @(negedge clk);
      m_memop = memw_M | regmem_M;
      m_abort = TO_EN && (waited == TO) && m_memop && !mem_ack;
      m_req   = m_memop && !m_abort;
      m_stall = m_memop && !mem_ack && !m_abort;
      if (started) begin
        check("m_mem_req", mem_req, m_req);
        check("m_stall", stall_M, m_stall);
        check("m_mem_we", mem_we, memw_M);
        if (m_memop) begin
          check("m_mem_addr", mem_addr, address_M);
          check("m_mem_wdata", mem_wdata, ALUrslt_M);
        end
        check("m_pcload_W", pcload_W, e_pc);
        check("m_regw_W", regw_W, e_rw);
        check("m_regScr_W", regScr_W, e_scr);
        check("m_result_W", result_W, e_res);
        check("m_address_W", address_W, e_addr);
        check("m_err_W", err_W, e_err);
      end
      if (!rst) begin
        e_pc = 1'b0; e_rw = 1'b0; e_err = 1'b0;
        e_scr = '0; e_res = '0; e_addr = '0;
        waited  = 0;
        started = 1'b1;
      end else if (started) begin
        if (m_stall) begin
          e_pc = 1'b0; e_rw = 1'b0; e_err = 1'b0;
          waited++;
        end else if (m_abort) begin
          e_pc = 1'b0; e_rw = 1'b0; e_err = 1'b1;
          waited = 0;
        end else begin
          e_pc   = pcload_M;
          e_rw   = regw_M;
          e_scr  = regScr_M;
          e_res  = regmem_M ? mem_rdata : ALUrslt_M;
          e_addr = address_M;
          e_err  = 1'b0;
          waited = 0;
        end
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge, then return just
  // after the falling edge so the caller can sample settled outputs.
  task automatic cyc(input logic r, input logic pc, input logic rw, input logic mw,
                     input logic rm, input logic [M-1:0] scr, input logic [N-1:0] alu,
                     input logic [N-1:0] addr, input logic ack, input logic [N-1:0] rd);
    @(posedge clk);
    #1;
    rst = r; pcload_M = pc; regw_M = rw; memw_M = mw; regmem_M = rm;
    regScr_M = scr; ALUrslt_M = alu; address_M = addr;
    mem_ack = ack; mem_rdata = rd;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b0; pcload_M = 1'b0; regw_M = 1'b0; memw_M = 1'b0; regmem_M = 1'b0;
    regScr_M = '0; ALUrslt_M = '0; address_M = '0; mem_ack = 1'b0; mem_rdata = '0;

    // Reset
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    check("rst_regw_W", regw_W, 0);
    check("rst_result_W", result_W, 0);
    check("rst_address_W", address_W, 0);
    check("rst_stall", stall_M, 0);

    // ALU-only op passes through with one cycle of latency
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 32'hAA, 32'h10, 1'b0, '0);
    check("alu_stall", stall_M, 0);
    check("alu_req", mem_req, 0);
    idle();
    check("alu_regw_W", regw_W, 1);
    check("alu_regScr_W", regScr_W, 3);
    check("alu_result_W", result_W, 32'hAA);
    check("alu_address_W", address_W, 32'h10);

    // Zero-wait load
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 32'h999, 32'h40, 1'b1, 32'h1234);
    check("zw_req", mem_req, 1);
    check("zw_we", mem_we, 0);
    check("zw_stall", stall_M, 0);
    check("zw_addr", mem_addr, 32'h40);
    idle();
    check("zw_result_W", result_W, 32'h1234);
    check("zw_regScr_W", regScr_W, 5);

    // Store acknowledged on the 4th cycle
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 32'hDEAD, 32'h80, 1'b0, '0);
    check("st_req", mem_req, 1);
    check("st_we", mem_we, 1);
    check("st_wdata", mem_wdata, 32'hDEAD);
    check("st_stall1", stall_M, 1);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 32'hDEAD, 32'h80, 1'b0, '0);
      check("st_stall23", stall_M, 1);
      check("st_bubble_regw", regw_W, 0);
      check("st_bubble_hold_addr", address_W, 0);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 32'hDEAD, 32'h80, 1'b1, 32'hFFFF);
    check("st_ack_stall", stall_M, 0);
    check("st_ack_req", mem_req, 1);
    idle();
    check("st_address_W", address_W, 32'h80);
    check("st_result_W", result_W, 32'hDEAD);
    check("st_regScr_W", regScr_W, 7);

    // Store and load flagged together: write, but write back memory data
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd6, 32'h77, 32'h90, 1'b1, 32'h5555);
    check("both_we", mem_we, 1);
    check("both_req", mem_req, 1);
    idle();
    check("both_result_W", result_W, 32'h5555);

    // Back-to-back: load with one wait, then an ALU op
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 32'h0, 32'h44, 1'b0, '0);
    check("b2b_stall_a", stall_M, 1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 32'h0, 32'h44, 1'b1, 32'hBEEF);
    check("b2b_stall_b", stall_M, 0);
    check("b2b_bubble_regw", regw_W, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 32'h33, 32'h200, 1'b0, '0);
    check("b2b_stall_c", stall_M, 0);
    check("b2b_load_result", result_W, 32'hBEEF);
    check("b2b_load_regw", regw_W, 1);
    check("b2b_load_regScr", regScr_W, 2);
    idle();
    check("b2b_alu_result", result_W, 32'h33);
    check("b2b_alu_pcload", pcload_W, 1);
    check("b2b_alu_address", address_W, 32'h200);

    // Reset asserted in the second cycle of a pending load
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 32'h1, 32'h3, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h8, 32'h0, 32'h50, 1'b0, '0);
    check("rw_stall1", stall_M, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h8, 32'h0, 32'h50, 1'b0, '0);
    check("rw_stall2", stall_M, 1);
    check("rw_hold_regScr", regScr_W, 4'hF);
    idle();
    check("rw_regScr_W", regScr_W, 0);
    check("rw_result_W", result_W, 0);
    check("rw_address_W", address_W, 0);
    check("rw_stall", stall_M, 0);

`ifdef MEM_TIMEOUT_EN
    // Load never acknowledged: 15 stall cycles, abort on the 16th
    for (int i = 0; i < TO; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 32'h0, 32'hA0, 1'b0, '0);
      check("to_stall", stall_M, 1);
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 32'h0, 32'hA0, 1'b0, '0);
    check("to_abort_req", mem_req, 0);
    check("to_abort_stall", stall_M, 0);
    idle();
    check("to_err_W", err_W, 1);
    check("to_err_regw", regw_W, 0);
    idle();
    check("to_err_clear", err_W, 0);
`else
    // Without the watchdog a long wait simply keeps stalling
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 32'h0, 32'hA0, 1'b0, '0);
      check("lw_stall", stall_M, 1);
      check("lw_req", mem_req, 1);
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 32'h0, 32'hA0, 1'b1, 32'hC0DE);
    check("lw_ack_stall", stall_M, 0);
    idle();
    check("lw_result_W", result_W, 32'hC0DE);
    check("lw_err_W", err_W, 0);
`endif

    idle();
    idle();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mem_stage_ctrl
